// File: rtl/key_expansion_engine.sv
// Sequential AES-128/192/256 key schedule: one 32-bit word per cycle into a word buffer,
// with a registered round-key read port in encrypt or decrypt order.

module sbox_element (
  input  logic [7:0] data_i,
  output logic [7:0] sub_c_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] inv_c;
  logic [7:0] sq_c;

  // Multiplicative inverse as x^254 (maps 0 to 0), then the AES affine transform
  always_comb begin
    inv_c = 8'h01;
    sq_c  = data_i;
    for (int k = 1; k < 8; k++) begin
      sq_c  = gf_mul(sq_c, sq_c);
      inv_c = gf_mul(inv_c, sq_c);
    end
    sub_c_o = inv_c ^ {inv_c[6:0], inv_c[7]} ^ {inv_c[5:0], inv_c[7:6]}
            ^ {inv_c[4:0], inv_c[7:5]} ^ {inv_c[3:0], inv_c[7:4]} ^ 8'h63;
  end

endmodule

module key_expansion_engine #(
  parameter int unsigned MAX_NK = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [1:0]   key_len_i,
  input  logic [255:0] key_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic         keys_valid_o,
  input  logic         rk_rd_en_i,
  input  logic [3:0]   rk_rd_round_i,
  input  logic         rk_rd_inv_i,
  output logic [127:0] rk_out_o,
  output logic         rk_valid_o
);

  localparam int unsigned NW_MAX = 4 * (MAX_NK + 7);
  localparam int unsigned IW     = $clog2(NW_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND, S_DONE} state_e;

  state_e         state_q;
  logic [255:0]   key_q;
  logic [3:0]     nk_q;
  logic [IW-1:0]  i_q;
  logic [2:0]     pos_q;
  logic [7:0]     rc_q;
  logic           busy_q, done_q, err_q, kv_q, rk_valid_q;
  logic [127:0]   rk_out_q;
  logic [31:0]    w_q [NW_MAX];

  logic [3:0]     nk_d;
  logic           legal_c;
  logic [31:0]    prev_c, back_c, sub_in_c, sub_c, t_c, word_d;
  logic           last_c, pos_wrap_c;
  logic [3:0]     nr_c, re_c;
  logic           rd_ok_c;
  logic [IW-1:0]  base_c;
  logic [127:0]   rk_c;

  always_comb begin
    case (key_len_i)
      2'b00:   nk_d = 4'd4;
      2'b01:   nk_d = 4'd6;
      2'b10:   nk_d = 4'd8;
      default: nk_d = 4'd0;
    endcase
    legal_c = (nk_d != 4'd0) && (32'(nk_d) <= MAX_NK);
  end

  // Next schedule word from w[i-1] and w[i-Nk]; pos_q tracks i mod Nk
  assign prev_c   = w_q[i_q - IW'(1)];
  assign back_c   = w_q[i_q - IW'(nk_q)];
  assign sub_in_c = (pos_q == 3'd0) ? {prev_c[23:0], prev_c[31:24]} : prev_c;

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    sbox_element u_sbox (
      .data_i  (sub_in_c[8*g +: 8]),
      .sub_c_o (sub_c[8*g +: 8])
    );
  end

  always_comb begin
    t_c = prev_c;
    if (pos_q == 3'd0)                        t_c = sub_c ^ {rc_q, 24'h000000};
    else if (nk_q == 4'd8 && pos_q == 3'd4)   t_c = sub_c;
    word_d = back_c ^ t_c;
  end

  assign last_c     = (i_q == IW'({nk_q, 2'b00}) + IW'(27));
  assign pos_wrap_c = (pos_q == 3'(nk_q - 4'd1));

  assign nr_c    = nk_q + 4'd6;
  assign re_c    = rk_rd_inv_i ? (nr_c - rk_rd_round_i) : rk_rd_round_i;
  assign rd_ok_c = kv_q && (rk_rd_round_i <= nr_c);
  assign base_c  = IW'({re_c, 2'b00});
  assign rk_c    = {w_q[base_c], w_q[base_c + IW'(1)], w_q[base_c + IW'(2)], w_q[base_c + IW'(3)]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      key_q      <= '0;
      nk_q       <= 4'd4;
      i_q        <= '0;
      pos_q      <= 3'd0;
      rc_q       <= 8'h01;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      kv_q       <= 1'b0;
      rk_valid_q <= 1'b0;
      rk_out_q   <= '0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rk_valid_q <= 1'b0;
      // Read uses pre-update kv_q/nk_q, so a read alongside a start sees the old schedule
      if (rk_rd_en_i) begin
        rk_valid_q <= rd_ok_c;
        rk_out_q   <= rd_ok_c ? rk_c : '0;
      end
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (legal_c) begin
              key_q   <= key_i;
              nk_q    <= nk_d;
              kv_q    <= 1'b0;
              busy_q  <= 1'b1;
              state_q <= S_LOAD;
            end else begin
              err_q   <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          i_q     <= IW'(nk_q);
          pos_q   <= 3'd0;
          rc_q    <= 8'h01;
          state_q <= S_EXPAND;
        end
        S_EXPAND: begin
          i_q   <= i_q + IW'(1);
          pos_q <= pos_wrap_c ? 3'd0 : pos_q + 3'd1;
          if (pos_q == 3'd0) rc_q <= {rc_q[6:0], 1'b0} ^ (rc_q[7] ? 8'h1b : 8'h00);
          if (last_c) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            kv_q    <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Word buffer is intentionally not reset
  always_ff @(posedge clk_i) begin
    if (state_q == S_LOAD) begin
      for (int k = 0; k < 8; k++) begin
        if (k < int'(nk_q)) w_q[IW'(k)] <= key_q[255 - 32*k -: 32];
      end
    end else if (state_q == S_EXPAND) begin
      w_q[i_q] <= word_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign keys_valid_o = kv_q;
  assign rk_out_o     = rk_out_q;
  assign rk_valid_o   = rk_valid_q;

endmodule

// File: tb/tb_key_expansion_engine.sv
// Directed bench for key_expansion_engine using FIPS-197 key schedule vectors.

module tb_key_expansion_engine;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic [1:0]   key_len_i = 2'b00;
  logic [255:0] key_i = '0;
  logic         busy_o, done_o, err_o, keys_valid_o;
  logic         rk_rd_en_i = 1'b0;
  logic [3:0]   rk_rd_round_i = 4'd0;
  logic         rk_rd_inv_i = 1'b0;
  logic [127:0] rk_out_o;
  logic         rk_valid_o;

  int checks = 0;
  int errors = 0;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R128_0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R192_0  = 128'h8e73b0f7da0e6452c810f32b809079e5;
  localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R256_0  = 128'h603deb1015ca71be2b73aef0857d7781;
  localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  always #5 clk = ~clk;

  key_expansion_engine #(.MAX_NK(8)) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .key_len_i     (key_len_i),
    .key_i         (key_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .err_o         (err_o),
    .keys_valid_o  (keys_valid_o),
    .rk_rd_en_i    (rk_rd_en_i),
    .rk_rd_round_i (rk_rd_round_i),
    .rk_rd_inv_i   (rk_rd_inv_i),
    .rk_out_o      (rk_out_o),
    .rk_valid_o    (rk_valid_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start an expansion (start sampled at cycle 0); optionally pulse an extra start at inject_at
  task automatic expand(input logic [1:0] len, input logic [255:0] key, input int inject_at,
                        output int done_cyc, output logic busy1);
    start_i = 1'b1; key_len_i = len; key_i = key;
    tick();
    start_i = 1'b0;
    busy1 = busy_o;
    done_cyc = -1;
    for (int c = 1; c <= 100; c++) begin
      if (c == inject_at) begin
        start_i = 1'b1; key_len_i = 2'b10; key_i = K256;
      end else begin
        start_i = 1'b0; key_len_i = len; key_i = key;
      end
      if (done_o) begin
        done_cyc = c;
        break;
      end
      tick();
    end
    start_i = 1'b0;
  endtask

  task automatic rd(input logic [3:0] round, input logic inv, output logic v, output logic [127:0] d);
    rk_rd_en_i = 1'b1; rk_rd_round_i = round; rk_rd_inv_i = inv;
    tick();
    rk_rd_en_i = 1'b0;
    v = rk_valid_o;
    d = rk_out_o;
  endtask

  task automatic test_reset();
    logic v; logic [127:0] d;
    rst_i = 1'b1; tick(); tick(); rst_i = 1'b0;
    checks++;
    if ({busy_o, done_o, err_o, keys_valid_o, rk_valid_o} !== 5'b0) begin
      errors++; $display("FAIL reset_flags: got %b want 00000", {busy_o, done_o, err_o, keys_valid_o, rk_valid_o});
    end
    checks++;
    if (rk_out_o !== 128'h0) begin errors++; $display("FAIL reset_rk_out: got %h want 0", rk_out_o); end
    rd(4'd0, 1'b0, v, d);
    checks++;
    if (v !== 1'b0 || d !== 128'h0) begin errors++; $display("FAIL reset_read: got v=%b %h want v=0 0", v, d); end
  endtask

  task automatic test_aes128();
    int dc; logic b1; logic v; logic [127:0] d;
    expand(2'b00, K128, 0, dc, b1);
    checks++;
    if (dc !== 42) begin errors++; $display("FAIL aes128_done_cycle: got %0d want 42", dc); end
    checks++;
    if (b1 !== 1'b1) begin errors++; $display("FAIL aes128_busy_c1: got %b want 1", b1); end
    checks++;
    if (keys_valid_o !== 1'b1) begin errors++; $display("FAIL aes128_kv: got %b want 1", keys_valid_o); end
    tick();
    checks++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      errors++; $display("FAIL aes128_done_pulse: got done=%b busy=%b want 0 0", done_o, busy_o);
    end
    rd(4'd0, 1'b0, v, d);
    checks++;
    if (v !== 1'b1 || d !== R128_0) begin errors++; $display("FAIL aes128_r0: got v=%b %h want v=1 %h", v, d, R128_0); end
    rd(4'd1, 1'b0, v, d);
    checks++;
    if (v !== 1'b1 || d !== R128_1) begin errors++; $display("FAIL aes128_r1: got v=%b %h want v=1 %h", v, d, R128_1); end
    rd(4'd10, 1'b0, v, d);
    checks++;
    if (v !== 1'b1 || d !== R128_10) begin errors++; $display("FAIL aes128_r10: got v=%b %h want v=1 %h", v, d, R128_10); end
  endtask

  task automatic test_inverse();
    logic v; logic [127:0] d;
    rd(4'd0, 1'b1, v, d);
    checks++;
    if (v !== 1'b1 || d !== R128_10) begin errors++; $display("FAIL inv_r0: got v=%b %h want v=1 %h", v, d, R128_10); end
    tick();
    checks++;
    if (rk_valid_o !== 1'b0 || rk_out_o !== R128_10) begin
      errors++; $display("FAIL read_hold: got v=%b %h want v=0 %h", rk_valid_o, rk_out_o, R128_10);
    end
    rd(4'd10, 1'b1, v, d);
    checks++;
    if (v !== 1'b1 || d !== R128_0) begin errors++; $display("FAIL inv_r10: got v=%b %h want v=1 %h", v, d, R128_0); end
    rd(4'd11, 1'b1, v, d);
    checks++;
    if (v !== 1'b0 || d !== 128'h0) begin errors++; $display("FAIL inv_r11: got v=%b %h want v=0 0", v, d); end
  endtask

  task automatic test_aes192();
    int dc; logic b1; logic v; logic [127:0] d;
    expand(2'b01, K192, 0, dc, b1);
    checks++;
    if (dc !== 48) begin errors++; $display("FAIL aes192_done_cycle: got %0d want 48", dc); end
    tick();
    rd(4'd12, 1'b0, v, d);
    checks++;
    if (v !== 1'b1 || d !== R192_12) begin errors++; $display("FAIL aes192_r12: got v=%b %h want v=1 %h", v, d, R192_12); end
    rd(4'd12, 1'b1, v, d);
    checks++;
    if (v !== 1'b1 || d !== R192_0) begin errors++; $display("FAIL aes192_inv12: got v=%b %h want v=1 %h", v, d, R192_0); end
    rd(4'd13, 1'b0, v, d);
    checks++;
    if (v !== 1'b0 || d !== 128'h0) begin errors++; $display("FAIL aes192_r13: got v=%b %h want v=0 0", v, d); end
  endtask

  task automatic test_aes256();
    int dc; logic b1; logic v; logic [127:0] d;
    expand(2'b10, K256, 0, dc, b1);
    checks++;
    if (dc !== 54) begin errors++; $display("FAIL aes256_done_cycle: got %0d want 54", dc); end
    tick();
    rd(4'd14, 1'b0, v, d);
    checks++;
    if (v !== 1'b1 || d !== R256_14) begin errors++; $display("FAIL aes256_r14: got v=%b %h want v=1 %h", v, d, R256_14); end
    rd(4'd0, 1'b1, v, d);
    checks++;
    if (v !== 1'b1 || d !== R256_14) begin errors++; $display("FAIL aes256_inv0: got v=%b %h want v=1 %h", v, d, R256_14); end
    rd(4'd0, 1'b0, v, d);
    checks++;
    if (v !== 1'b1 || d !== R256_0) begin errors++; $display("FAIL aes256_r0: got v=%b %h want v=1 %h", v, d, R256_0); end
  endtask

  task automatic test_err_and_ignore();
    int dc; logic b1; logic v; logic [127:0] d;
    start_i = 1'b1; key_len_i = 2'b11; key_i = K128;
    tick();
    start_i = 1'b0;
    checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL err_pulse: got err=%b busy=%b want 1 0", err_o, busy_o);
    end
    tick();
    checks++;
    if (err_o !== 1'b0 || busy_o !== 1'b0 || keys_valid_o !== 1'b1) begin
      errors++; $display("FAIL err_after: got err=%b busy=%b kv=%b want 0 0 1", err_o, busy_o, keys_valid_o);
    end
    expand(2'b00, K128, 10, dc, b1);
    checks++;
    if (dc !== 42) begin errors++; $display("FAIL ignore_start_done: got %0d want 42", dc); end
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("FAIL ignore_start_err: got %b want 0", err_o); end
    tick();
    rd(4'd10, 1'b0, v, d);
    checks++;
    if (v !== 1'b1 || d !== R128_10) begin errors++; $display("FAIL ignore_start_r10: got v=%b %h want v=1 %h", v, d, R128_10); end
  endtask

  task automatic test_back_to_back();
    int dc;
    rk_rd_en_i = 1'b1; rk_rd_round_i = 4'd10; rk_rd_inv_i = 1'b0;
    start_i = 1'b1; key_len_i = 2'b10; key_i = K256;
    tick();
    rk_rd_en_i = 1'b0; start_i = 1'b0;
    checks++;
    if (rk_valid_o !== 1'b1 || rk_out_o !== R128_10) begin
      errors++; $display("FAIL rd_with_start: got v=%b %h want v=1 %h", rk_valid_o, rk_out_o, R128_10);
    end
    checks++;
    if (keys_valid_o !== 1'b0 || busy_o !== 1'b1) begin
      errors++; $display("FAIL start_clears_kv: got kv=%b busy=%b want 0 1", keys_valid_o, busy_o);
    end
    dc = -1;
    for (int c = 1; c <= 100; c++) begin
      if (done_o) begin dc = c; break; end
      tick();
    end
    checks++;
    if (dc !== 54) begin errors++; $display("FAIL b2b_done_cycle: got %0d want 54", dc); end
    tick();
  endtask

  task automatic test_rst_mid();
    int dc; logic b1; logic v; logic [127:0] d; int seen;
    start_i = 1'b1; key_len_i = 2'b10; key_i = K256;
    tick();
    start_i = 1'b0;
    for (int c = 1; c < 19; c++) tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || keys_valid_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_state: got busy=%b kv=%b want 0 0", busy_o, keys_valid_o);
    end
    rd(4'd0, 1'b0, v, d);
    checks++;
    if (v !== 1'b0 || d !== 128'h0) begin errors++; $display("FAIL rst_mid_read: got v=%b %h want v=0 0", v, d); end
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (done_o || busy_o) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rst_mid_idle: got %0d active cycles want 0", seen); end
    expand(2'b00, K128, 0, dc, b1);
    checks++;
    if (dc !== 42) begin errors++; $display("FAIL restart_done: got %0d want 42", dc); end
    tick();
    rd(4'd10, 1'b0, v, d);
    checks++;
    if (v !== 1'b1 || d !== R128_10) begin errors++; $display("FAIL restart_r10: got v=%b %h want v=1 %h", v, d, R128_10); end
  endtask

  initial begin
    test_reset();
    test_aes128();
    test_inverse();
    test_aes192();
    test_aes256();
    test_err_and_ignore();
    test_back_to_back();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
